de_pipe_reg: RTL and testbench
==============================

// Module: de_pipe_reg
// PURPOSE
//  D->E pipeline register of the 5-stage MIPS core. Captures the decoded D-stage
//  instruction, PC values and operands at each clk edge and presents them to the E
//  stage and to the E-stage write-back decoder (IR_E, PC8_E, lui_E, Tnew_E).
//  Inserts bubbles on stall/flush, freezes on hold, and counts inserted bubbles.
// PARAMETERS
//  RESET_PC  32'h0000_3000  PC_E value after reset; PC8_E resets to RESET_PC+8
//  CNT_W     16             width of bubble_cnt (saturating)
// PORTS
//  clk         in   1   rising-edge clock
//  reset       in   1   synchronous, active-low reset
//  IR_D        in   32  D-stage instruction
//  PC_D        in   32  D-stage PC
//  RS_D        in   32  forwarded rs operand in D
//  RT_D        in   32  forwarded rt operand in D
//  EXT_D       in   32  D-stage extended immediate
//  stall       in   1   hazard unit stall: insert bubble into E, D holds externally
//  flush       in   1   kill the D-stage instruction: insert bubble into E
//  hold        in   1   freeze E stage (reserved for multi-cycle units)
//  IR_E        out  32  E-stage instruction (0 = nop)
//  PC_E        out  32  E-stage PC
//  PC8_E       out  32  E-stage PC+8 (link value)
//  RS_E        out  32  E-stage rs operand
//  RT_E        out  32  E-stage rt operand
//  EXT_E       out  32  E-stage immediate
//  lui_E       out  32  {IR[15:0],16'b0} of the E-stage instruction
//  valid_E     out  1   1 = real instruction in E, 0 = bubble
//  Tnew_E      out  2   cycles until E-stage result is available, at E entry
//  bubble_cnt  out  CNT_W  number of bubbles inserted since reset
// BEHAVIOUR
//  - All state updates on posedge clk only; no combinational path input->output.
//  - Priority per edge: reset==0 > flush > hold > stall > normal load.
//  - Reset (reset==0): IR_E,RS_E,RT_E,EXT_E,lui_E=0; PC_E=RESET_PC;
//    PC8_E=RESET_PC+8; valid_E=0; Tnew_E=0; bubble_cnt=0.
//  - Normal load: every output takes its D value; PC8_E=PC_D+8 (mod 2^32);
//    lui_E={IR_D[15:0],16'b0}; valid_E=1; Tnew_E from IR_D:
//    lw (op 100011) -> 2; addu/subu (op 0, func 100001/100011), ori (001101),
//    lui (001111) -> 1; all others (sw, beq, jal, jr, jalr, nop, unknown) -> 0.
//  - Bubble (flush=1, or stall=1 with hold=0): IR_E,RS_E,RT_E,EXT_E,lui_E=0;
//    valid_E=0; Tnew_E=0; PC_E=PC_D, PC8_E=PC_D+8 (PC of the displaced instr kept).
//  - Hold (hold=1, flush=0): every output keeps its value; stall ignored;
//    bubble_cnt unchanged.
//  - bubble_cnt: +1 on each bubble edge; saturates at all-ones, never wraps.
//  - Latency: exactly one cycle D->E; back-to-back loads every cycle.
//  - Reset asserted mid-stall/hold: reset wins that edge; no residue next cycle.
// TESTING
//  1 reset=0 two edges -> IR_E=0, PC_E=32'h3000, PC8_E=32'h3008, valid_E=0,
//    Tnew_E=0, bubble_cnt=0.
//  2 IR_D=32'h8C0A0004 (lw), PC_D=32'h3010 -> next edge IR_E=32'h8C0A0004,
//    PC8_E=32'h3018, Tnew_E=2, valid_E=1; IR_D=32'h3C011234 (lui) -> lui_E=32'h12340000,
//    Tnew_E=1; IR_D=32'h0C000C00 (jal) -> Tnew_E=0.
//  3 stall=1 for 3 edges with PC_D=32'h3020 -> IR_E=0, valid_E=0, PC_E=32'h3020,
//    bubble_cnt=3; stall=0 -> D instr loads next edge.
//  4 hold=1 with stall=1 and new IR_D -> all outputs unchanged, bubble_cnt
//    unchanged; hold=1,flush=1 -> bubble inserted, bubble_cnt+1.
//  5 force bubble_cnt to all-ones via 65535 stalls, one more stall -> stays 16'hFFFF.
//  6 reset=0 while hold=1 and stall=1 -> reset values of test 1 on that edge.

Source files
------------

// File: rtl/de_pipe_reg.sv
// D->E pipeline register: captures the decoded instruction, PCs and operands,
// inserts bubbles on stall/flush, freezes on hold and counts inserted bubbles.
module de_pipe_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      IR_D,
    input  logic [31:0]      PC_D,
    input  logic [31:0]      RS_D,
    input  logic [31:0]      RT_D,
    input  logic [31:0]      EXT_D,
    input  logic             stall,
    input  logic             flush,
    input  logic             hold,
    output logic [31:0]      IR_E,
    output logic [31:0]      PC_E,
    output logic [31:0]      PC8_E,
    output logic [31:0]      RS_E,
    output logic [31:0]      RT_E,
    output logic [31:0]      EXT_E,
    output logic [31:0]      lui_E,
    output logic             valid_E,
    output logic [1:0]       Tnew_E,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [5:0] OpSpecial = 6'b000000;
    localparam logic [5:0] OpLw      = 6'b100011;
    localparam logic [5:0] OpOri     = 6'b001101;
    localparam logic [5:0] OpLui     = 6'b001111;
    localparam logic [5:0] FnAddu    = 6'b100001;
    localparam logic [5:0] FnSubu    = 6'b100011;

    // Cycles until the E-stage result is ready, as seen at E entry.
    function automatic logic [1:0] tnew_of(input logic [31:0] ir);
        logic [1:0] t;
        t = 2'd0;
        case (ir[31:26])
            OpLw:      t = 2'd2;
            OpOri:     t = 2'd1;
            OpLui:     t = 2'd1;
            OpSpecial: begin
                if (ir[5:0] == FnAddu || ir[5:0] == FnSubu) begin
                    t = 2'd1;
                end
            end
            default:   t = 2'd0;
        endcase
        return t;
    endfunction

    logic [31:0]      ir_q, ir_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      pc8_q, pc8_d;
    logic [31:0]      rs_q, rs_d;
    logic [31:0]      rt_q, rt_d;
    logic [31:0]      ext_q, ext_d;
    logic [31:0]      lui_q, lui_d;
    logic             valid_q, valid_d;
    logic [1:0]       tnew_q, tnew_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic do_bubble;
    logic do_hold;

    // flush outranks hold; hold outranks stall.
    assign do_bubble = flush | (stall & ~hold);
    assign do_hold   = hold & ~flush;

    always_comb begin
        ir_d    = ir_q;
        pc_d    = pc_q;
        pc8_d   = pc8_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        ext_d   = ext_q;
        lui_d   = lui_q;
        valid_d = valid_q;
        tnew_d  = tnew_q;
        cnt_d   = cnt_q;
        if (do_bubble) begin
            ir_d    = 32'd0;
            pc_d    = PC_D;
            pc8_d   = PC_D + 32'd8;
            rs_d    = 32'd0;
            rt_d    = 32'd0;
            ext_d   = 32'd0;
            lui_d   = 32'd0;
            valid_d = 1'b0;
            tnew_d  = 2'd0;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (!do_hold) begin
            ir_d    = IR_D;
            pc_d    = PC_D;
            pc8_d   = PC_D + 32'd8;
            rs_d    = RS_D;
            rt_d    = RT_D;
            ext_d   = EXT_D;
            lui_d   = {IR_D[15:0], 16'b0};
            valid_d = 1'b1;
            tnew_d  = tnew_of(IR_D);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ir_q    <= 32'd0;
            pc_q    <= RESET_PC;
            pc8_q   <= RESET_PC + 32'd8;
            rs_q    <= 32'd0;
            rt_q    <= 32'd0;
            ext_q   <= 32'd0;
            lui_q   <= 32'd0;
            valid_q <= 1'b0;
            tnew_q  <= 2'd0;
            cnt_q   <= '0;
        end else begin
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            pc8_q   <= pc8_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            ext_q   <= ext_d;
            lui_q   <= lui_d;
            valid_q <= valid_d;
            tnew_q  <= tnew_d;
            cnt_q   <= cnt_d;
        end
    end

    assign IR_E       = ir_q;
    assign PC_E       = pc_q;
    assign PC8_E      = pc8_q;
    assign RS_E       = rs_q;
    assign RT_E       = rt_q;
    assign EXT_E      = ext_q;
    assign lui_E      = lui_q;
    assign valid_E    = valid_q;
    assign Tnew_E     = tnew_q;
    assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_de_pipe_reg.sv
// Bench for de_pipe_reg: directed vector table, randomized run against a
// rule-level model, and bubble counter saturation.
module tb_de_pipe_reg;

    typedef struct {
        logic [31:0] ir, pc, pc8, rs, rt, ext, lui;
        logic        valid;
        logic [1:0]  tnew;
        logic [15:0] cnt;
    } outs_t;

    typedef struct {
        logic        rst, stall, flush, hold;
        logic [31:0] ir, pc, rs, rt, ext;
        outs_t       exp;
    } row_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IR_D, PC_D, RS_D, RT_D, EXT_D;
    logic        stall, flush, hold;
    logic [31:0] IR_E, PC_E, PC8_E, RS_E, RT_E, EXT_E, lui_E;
    logic        valid_E;
    logic [1:0]  Tnew_E;
    logic [15:0] bubble_cnt;

    int    n_cmp = 0;
    int    n_bad = 0;
    outs_t model;
    row_t  tbl[14];

    always #5 clk = ~clk;

    de_pipe_reg dut (
        .clk(clk), .reset(reset),
        .IR_D(IR_D), .PC_D(PC_D), .RS_D(RS_D), .RT_D(RT_D), .EXT_D(EXT_D),
        .stall(stall), .flush(flush), .hold(hold),
        .IR_E(IR_E), .PC_E(PC_E), .PC8_E(PC8_E), .RS_E(RS_E), .RT_E(RT_E),
        .EXT_E(EXT_E), .lui_E(lui_E), .valid_E(valid_E), .Tnew_E(Tnew_E),
        .bubble_cnt(bubble_cnt)
    );

    function automatic logic [1:0] ref_tnew(input logic [31:0] ir);
        logic [5:0] op, fn;
        op = ir[31:26];
        fn = ir[5:0];
        if (op == 6'h23) return 2'd2;
        if (op == 6'h0d || op == 6'h0f) return 2'd1;
        if (op == 6'h00 && (fn == 6'h21 || fn == 6'h23)) return 2'd1;
        return 2'd0;
    endfunction

    function automatic outs_t mk(input logic [31:0] ir, pc, pc8, rs, rt, ext, lui,
                                 input logic v, input logic [1:0] t,
                                 input logic [15:0] c);
        outs_t o;
        o.ir = ir; o.pc = pc; o.pc8 = pc8; o.rs = rs; o.rt = rt; o.ext = ext;
        o.lui = lui; o.valid = v; o.tnew = t; o.cnt = c;
        return o;
    endfunction

    function automatic row_t rw(input logic r, s, f, h,
                                input logic [31:0] ir, pc, rs, rt, ext,
                                input outs_t e);
        row_t x;
        x.rst = r; x.stall = s; x.flush = f; x.hold = h;
        x.ir = ir; x.pc = pc; x.rs = rs; x.rt = rt; x.ext = ext; x.exp = e;
        return x;
    endfunction

    task automatic chk(input string tag, input int idx, input string fld,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] %s: got %h, want %h", tag, idx, fld, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int idx, input outs_t e);
        chk(tag, idx, "IR_E", IR_E, e.ir);
        chk(tag, idx, "PC_E", PC_E, e.pc);
        chk(tag, idx, "PC8_E", PC8_E, e.pc8);
        chk(tag, idx, "RS_E", RS_E, e.rs);
        chk(tag, idx, "RT_E", RT_E, e.rt);
        chk(tag, idx, "EXT_E", EXT_E, e.ext);
        chk(tag, idx, "lui_E", lui_E, e.lui);
        chk(tag, idx, "valid_E", {31'd0, valid_E}, {31'd0, e.valid});
        chk(tag, idx, "Tnew_E", {30'd0, Tnew_E}, {30'd0, e.tnew});
        chk(tag, idx, "bubble_cnt", {16'd0, bubble_cnt}, {16'd0, e.cnt});
    endtask

    // Apply one edge of stimulus and advance the reference model by the same rules.
    task automatic drive(input logic r, s, f, h, input logic [31:0] ir, pc, rs, rt, ext);
        reset = r; stall = s; flush = f; hold = h;
        IR_D = ir; PC_D = pc; RS_D = rs; RT_D = rt; EXT_D = ext;
        @(posedge clk);
        #1;
        if (!r) begin
            model = mk(0, 32'h3000, 32'h3008, 0, 0, 0, 0, 0, 0, 0);
        end else if (f || (s && !h)) begin
            model = mk(0, pc, pc + 32'd8, 0, 0, 0, 0, 0, 0,
                       (model.cnt == 16'hFFFF) ? model.cnt : model.cnt + 16'd1);
        end else if (!h) begin
            model = mk(ir, pc, pc + 32'd8, rs, rt, ext, {ir[15:0], 16'h0}, 1,
                       ref_tnew(ir), model.cnt);
        end
    endtask

    function automatic logic [31:0] rand_ir();
        logic [31:0] ir;
        ir = $urandom;
        case ($urandom_range(0, 7))
            0: ir[31:26] = 6'h23;
            1: ir[31:26] = 6'h2b;
            2: ir[31:26] = 6'h0d;
            3: ir[31:26] = 6'h0f;
            4: ir[31:26] = 6'h04;
            5: ir[31:26] = 6'h03;
            6: begin
                ir[31:26] = 6'h00;
                case ($urandom_range(0, 3))
                    0: ir[5:0] = 6'h21;
                    1: ir[5:0] = 6'h23;
                    2: ir[5:0] = 6'h08;
                    default: ir[5:0] = 6'h09;
                endcase
            end
            default: ;
        endcase
        return ir;
    endfunction

    initial begin
        outs_t rst_o, ld_addu;
        model = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_o = mk(0, 32'h3000, 32'h3008, 0, 0, 0, 0, 0, 2'd0, 16'd0);
        ld_addu = mk(32'h00851021, 32'h3020, 32'h3028, 32'hAA, 32'hBB, 32'h1021,
                     32'h10210000, 1, 2'd1, 16'd3);

        tbl[0]  = rw(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, rst_o);
        tbl[1]  = rw(0, 0, 0, 0, 32'h8C0A0004, 32'h3010, 32'h1, 32'h2, 32'h3, rst_o);
        tbl[2]  = rw(1, 0, 0, 0, 32'h8C0A0004, 32'h3010, 32'h11, 32'h22, 32'h4,
                     mk(32'h8C0A0004, 32'h3010, 32'h3018, 32'h11, 32'h22, 32'h4,
                        32'h00040000, 1, 2'd2, 16'd0));
        tbl[3]  = rw(1, 0, 0, 0, 32'h3C011234, 32'h3014, 32'h33, 32'h44, 32'h1234,
                     mk(32'h3C011234, 32'h3014, 32'h301C, 32'h33, 32'h44, 32'h1234,
                        32'h12340000, 1, 2'd1, 16'd0));
        tbl[4]  = rw(1, 0, 0, 0, 32'h0C000C00, 32'h3018, 32'h55, 32'h66, 32'h0C00,
                     mk(32'h0C000C00, 32'h3018, 32'h3020, 32'h55, 32'h66, 32'h0C00,
                        32'h0C000000, 1, 2'd0, 16'd0));
        for (int i = 0; i < 3; i++) begin
            tbl[5+i] = rw(1, 1, 0, 0, 32'h00851021, 32'h3020, 32'h77, 32'h88, 32'h99,
                          mk(0, 32'h3020, 32'h3028, 0, 0, 0, 0, 0, 2'd0, 16'(i + 1)));
        end
        tbl[8]  = rw(1, 0, 0, 0, 32'h00851021, 32'h3020, 32'hAA, 32'hBB, 32'h1021, ld_addu);
        tbl[9]  = rw(1, 1, 0, 1, 32'h3C01FFFF, 32'h3030, 32'hCC, 32'hCC, 32'hCC, ld_addu);
        tbl[10] = rw(1, 0, 1, 1, 32'h3C01FFFF, 32'h3030, 32'hCC, 32'hCC, 32'hCC,
                     mk(0, 32'h3030, 32'h3038, 0, 0, 0, 0, 0, 2'd0, 16'd4));
        tbl[11] = rw(1, 0, 0, 0, 32'h34210001, 32'h3034, 32'hDD, 32'hEE, 32'h1,
                     mk(32'h34210001, 32'h3034, 32'h303C, 32'hDD, 32'hEE, 32'h1,
                        32'h00010000, 1, 2'd1, 16'd4));
        tbl[12] = rw(0, 1, 0, 1, 32'h8C0A0004, 32'h3050, 32'hF0, 32'hF1, 32'hF2, rst_o);
        tbl[13] = rw(1, 0, 0, 0, 32'hAC010000, 32'h3040, 32'h12, 32'h34, 32'h0,
                     mk(32'hAC010000, 32'h3040, 32'h3048, 32'h12, 32'h34, 32'h0,
                        32'h0, 1, 2'd0, 16'd0));

        reset = 0; stall = 0; flush = 0; hold = 0;
        IR_D = 0; PC_D = 0; RS_D = 0; RT_D = 0; EXT_D = 0;
        #2;

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].rst, tbl[i].stall, tbl[i].flush, tbl[i].hold,
                  tbl[i].ir, tbl[i].pc, tbl[i].rs, tbl[i].rt, tbl[i].ext);
            chk_all("vec", i, tbl[i].exp);
        end

        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 49) != 0),
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 6) == 0),
                  rand_ir(), $urandom, $urandom, $urandom, $urandom);
            chk_all("rnd", i, model);
        end

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 65534; i++) begin
            drive(1, 1, 0, 0, rand_ir(), 32'h4000, $urandom, $urandom, $urandom);
        end
        chk("sat", 0, "bubble_cnt", {16'd0, bubble_cnt}, 32'h0000FFFE);
        drive(1, 1, 0, 0, 32'h8C0A0004, 32'h4000, 1, 2, 3);
        chk("sat", 1, "bubble_cnt", {16'd0, bubble_cnt}, 32'h0000FFFF);
        drive(1, 1, 0, 0, 32'h8C0A0004, 32'h4000, 1, 2, 3);
        chk("sat", 2, "bubble_cnt", {16'd0, bubble_cnt}, 32'h0000FFFF);
        drive(1, 0, 1, 0, 32'h8C0A0004, 32'h4004, 1, 2, 3);
        chk_all("sat", 3, model);
        drive(1, 0, 0, 0, 32'h3C01BEEF, 32'h4008, 4, 5, 6);
        chk_all("sat", 4, model);
        chk("sat", 5, "bubble_cnt", {16'd0, bubble_cnt}, 32'h0000FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
